xpat_err_sweep_ctrl: RTL and testbench

//  Sequencer that evaluates an approximate adder (e.g. a generated adder_i4_o3 SOP netlist) against exact addition.

---
 rtl/xpat_err_sweep_ctrl.sv | 146 ++++++++++++++
 tb/tb_xpat_err_sweep_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/xpat_err_sweep_ctrl.sv
// xpat_err_sweep_ctrl: sweeps every input vector through an external approximate adder and scores it against exact addition.
// Optional total-error accumulator and err_sum port enabled by defining XPAT_ERR_SUM_EN.
module xpat_err_sweep_ctrl #(
    parameter int N_IN    = 4,
    parameter int N_OUT   = 3,
    parameter int ET      = 0,
    parameter int DUT_LAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN-1:0]   dut_in,
    input  logic [N_OUT-1:0]  dut_out,
    output logic [N_OUT-1:0]  max_err,
    output logic [N_IN:0]     err_cnt,
    output logic              fail_valid,
    output logic [N_IN-1:0]   fail_vec
`ifdef XPAT_ERR_SUM_EN
    ,
    output logic [2*N_IN:0]   err_sum
`endif
);
    localparam int H  = N_IN / 2;
    localparam int PW = 1 + N_IN + N_OUT;

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

    state_t             state;
    logic [2:0]         dcnt;
    logic               go;
    logic [N_OUT-1:0]   exact;
    logic [PW-1:0]      s0;
    logic [PW-1:0]      al;
    logic               al_v;
    logic [N_IN-1:0]    al_vec;
    logic [N_OUT-1:0]   al_sum;
    logic [N_OUT-1:0]   diff;
    logic               er_v;
    logic [N_OUT-1:0]   er;
    logic [N_IN-1:0]    er_vec;

    assign go     = start & ~abort & (state == IDLE || state == DONE);
    assign busy   = state == SWEEP || state == DRAIN;
    assign pass   = state == DONE && !fail_valid;
    assign exact  = N_OUT'(dut_in[H-1:0]) + N_OUT'(dut_in[N_IN-1:H]);
    assign s0     = {state == SWEEP, dut_in, exact};
    assign al_v   = al[PW-1];
    assign al_vec = al[N_OUT +: N_IN];
    assign al_sum = al[N_OUT-1:0];
    assign diff   = al_sum >= dut_out ? al_sum - dut_out : dut_out - al_sum;

    // The issued vector and its exact sum travel with the adder latency so they meet dut_out
    generate
        if (DUT_LAT == 0) begin : g_nolat
            assign al = s0;
        end else begin : g_lat
            logic [PW-1:0] sr [DUT_LAT];
            always_ff @(posedge clk) begin
                if (rst || abort) begin
                    for (int i = 0; i < DUT_LAT; i++) sr[i] <= '0;
                end else begin
                    sr[0] <= s0;
                    for (int i = 1; i < DUT_LAT; i++) sr[i] <= sr[i-1];
                end
            end
            assign al = sr[DUT_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            er_v   <= 1'b0;
            er     <= '0;
            er_vec <= '0;
        end else begin
            er_v   <= al_v;
            er     <= al_v ? diff : '0;
            er_vec <= al_vec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dut_in     <= '0;
            dcnt       <= '0;
            done       <= 1'b0;
            max_err    <= '0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
`ifdef XPAT_ERR_SUM_EN
            err_sum    <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (abort) begin
                state  <= IDLE;
                dut_in <= '0;
            end else begin
                case (state)
                    IDLE, DONE: if (start) begin
                        state  <= SWEEP;
                        dut_in <= '0;
                    end
                    SWEEP: if (&dut_in) begin
                        state <= DRAIN;
                        dcnt  <= '0;
                    end else begin
                        dut_in <= dut_in + N_IN'(1);
                    end
                    DRAIN: if (dcnt == 3'(DUT_LAT)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        dcnt <= dcnt + 3'd1;
                    end
                    default: state <= IDLE;
                endcase
            end
            if (go) begin
                max_err    <= '0;
                err_cnt    <= '0;
                fail_valid <= 1'b0;
                fail_vec   <= '0;
`ifdef XPAT_ERR_SUM_EN
                err_sum    <= '0;
`endif
            end else if (er_v) begin
                if (er > max_err) max_err <= er;
                if (|er) err_cnt <= err_cnt + (N_IN+1)'(1);
                if (!fail_valid && int'(er) > ET) begin
                    fail_valid <= 1'b1;
                    fail_vec   <= er_vec;
                end
`ifdef XPAT_ERR_SUM_EN
                err_sum <= err_sum + (2*N_IN+1)'(er);
`endif
            end
        end
    end
endmodule

// File: tb/tb_xpat_err_sweep_ctrl.sv
// tb_xpat_err_sweep_ctrl: three controllers (ET=0, ET=1, DUT_LAT=2) sweep table-driven adders and are scored against a sweep model.
module tb_xpat_err_sweep_ctrl;
    logic clk = 1'b0;
    logic rst, start, abort;
    logic busy [3], done [3], pass [3], fv [3];
    logic [3:0] din [3], fvec [3], d1, d2;
    logic [2:0] dout [3], mx [3];
    logic [4:0] ec [3];
`ifdef XPAT_ERR_SUM_EN
    logic [8:0] es [3];
`endif
    logic [2:0] lut [16];
    int errors = 0, checks = 0;
    int ets [3] = '{0, 1, 0};
    int lats [3] = '{0, 0, 2};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        d1 <= din[2];
        d2 <= d1;
    end

    for (genvar g = 0; g < 3; g++) begin : g_u
        assign dout[g] = (g == 2) ? lut[d2] : lut[din[g]];
        xpat_err_sweep_ctrl #(.N_IN(4), .N_OUT(3), .ET(g == 1 ? 1 : 0), .DUT_LAT(g == 2 ? 2 : 0)) u (
            .clk(clk), .rst(rst), .start(start), .abort(abort),
            .busy(busy[g]), .done(done[g]), .pass(pass[g]),
            .dut_in(din[g]), .dut_out(dout[g]),
            .max_err(mx[g]), .err_cnt(ec[g]), .fail_valid(fv[g]), .fail_vec(fvec[g])
`ifdef XPAT_ERR_SUM_EN
            , .err_sum(es[g])
`endif
        );
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // mode 0 exact, 1 tied to zero, 2 out[0] stuck-at-0, 3 random outputs
    task automatic set_mode(input int m);
        for (int v = 0; v < 16; v++) begin
            int s = (v % 4) + (v / 4);
            lut[v] = m == 0 ? 3'(s) : m == 1 ? 3'd0 : m == 2 ? 3'(s & 6) : 3'($urandom_range(0, 7));
        end
    endtask

    task automatic model(input int et, output int m, output int c, output int f, output int fw, output int sum);
        m = 0; c = 0; f = 0; fw = 0; sum = 0;
        for (int v = 0; v < 16; v++) begin
            int e = (v % 4) + (v / 4) - int'(lut[v]);
            if (e < 0) e = -e;
            if (e > m) m = e;
            if (e != 0) c++;
            if (e > et && f == 0) begin f = 1; fw = v; end
            sum += e;
        end
    endtask

    task automatic run(input string nm, input bit mid_start);
        int dc [3], np [3];
        int m, c, f, fw, sum;
        for (int i = 0; i < 3; i++) begin dc[i] = -1; np[i] = 0; end
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) if (done[i]) begin
                np[i]++;
                if (dc[i] < 0) dc[i] = k;
            end
            start = mid_start && k == 4;
        end
        for (int i = 0; i < 3; i++) begin
            model(ets[i], m, c, f, fw, sum);
            check($sformatf("%s[%0d].done_cycle", nm, i), dc[i], 17 + lats[i]);
            check($sformatf("%s[%0d].done_pulses", nm, i), np[i], 1);
            check($sformatf("%s[%0d].busy", nm, i), busy[i], 0);
            check($sformatf("%s[%0d].max_err", nm, i), mx[i], m);
            check($sformatf("%s[%0d].err_cnt", nm, i), ec[i], c);
            check($sformatf("%s[%0d].fail_valid", nm, i), fv[i], f);
            check($sformatf("%s[%0d].pass", nm, i), pass[i], !f);
            check($sformatf("%s[%0d].fail_vec", nm, i), fvec[i], fw);
`ifdef XPAT_ERR_SUM_EN
            check($sformatf("%s[%0d].err_sum", nm, i), es[i], sum);
`endif
        end
    endtask

    task automatic check_reset(input string nm);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s[%0d].busy", nm, i), busy[i], 0);
            check($sformatf("%s[%0d].done", nm, i), done[i], 0);
            check($sformatf("%s[%0d].pass", nm, i), pass[i], 0);
            check($sformatf("%s[%0d].dut_in", nm, i), din[i], 0);
            check($sformatf("%s[%0d].max_err", nm, i), mx[i], 0);
            check($sformatf("%s[%0d].err_cnt", nm, i), ec[i], 0);
            check($sformatf("%s[%0d].fail_valid", nm, i), fv[i], 0);
            check($sformatf("%s[%0d].fail_vec", nm, i), fvec[i], 0);
`ifdef XPAT_ERR_SUM_EN
            check($sformatf("%s[%0d].err_sum", nm, i), es[i], 0);
`endif
        end
    endtask

    initial begin
        int np;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        set_mode(0);
        repeat (3) @(posedge clk);
        #1 check_reset("reset");
        @(negedge clk) rst = 1'b0;
        run("exact", 1'b0);
        run("zero", 1'b0);
        set_mode(2);
        run("stuck0", 1'b0);
        for (int r = 0; r < 3; r++) begin
            set_mode(3);
            run($sformatf("rand%0d", r), r == 1);
        end
        set_mode(0);
        run("exact_mid_start", 1'b1);
        // abort after a failing run: the new start must have cleared the old statistics
        set_mode(1);
        run("zero2", 1'b0);
        set_mode(0);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk) abort = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("abort[%0d].busy", i), busy[i], 0);
            check($sformatf("abort[%0d].dut_in", i), din[i], 0);
            check($sformatf("abort[%0d].max_err", i), mx[i], 0);
            check($sformatf("abort[%0d].err_cnt", i), ec[i], 0);
            check($sformatf("abort[%0d].fail_valid", i), fv[i], 0);
        end
        abort = 1'b0;
        np = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) if (done[i] || busy[i]) np++;
        end
        check("abort.no_activity", np, 0);
        run("after_abort", 1'b0);
        set_mode(1);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 check_reset("rst_mid");
        rst = 1'b0;
        set_mode(0);
        run("after_rst", 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
